// File: rtl/one_seq_div_sixteen_by_eight.sv
// Sequential 16/8 restoring divider: one quotient bit per clock, 8 steps per operation.
// Optional macro DIV_PRECHECK_EN rejects divide-by-zero/overflow operands up front and raises err.
module one_seq_div_sixteen_by_eight (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] N_in,
   input  logic [7:0]  D_in,
   output logic [7:0]  Q_out,
   output logic [7:0]  R_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  cnt;
   logic [7:0]  rem;
   logic [7:0]  dvd_lo;
   logic [7:0]  dvs;
   logic [7:0]  quo;

   logic [8:0]  rem9;
   logic [8:0]  diff;
   logic        ge;
   logic [7:0]  rem_step;
   logic [7:0]  quo_step;
   logic        last;
   logic        accept;
   logic        reject;

`ifdef DIV_PRECHECK_EN
   // Quotient cannot fit in 8 bits when the high byte already reaches the divisor.
   assign reject = (D_in == 8'd0) || (N_in[15:8] >= D_in);
`else
   assign reject = 1'b0;
`endif

   assign accept = (state == IDLE) && start;
   assign last   = (state == CALC) && (cnt == 3'd7);
   assign busy   = (state != IDLE);

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem9     = {rem, dvd_lo[7]};
      diff     = rem9 - {1'b0, dvs};
      ge       = (rem9 >= {1'b0, dvs});
      rem_step = ge ? diff[7:0] : rem9[7:0];
      quo_step = {quo[6:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = reject ? DONE : CALC;
         CALC: if (cnt == 3'd7) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 3'd0;
         rem    <= 8'd0;
         dvd_lo <= 8'd0;
         dvs    <= 8'd0;
         quo    <= 8'd0;
         Q_out  <= 8'd0;
         R_out  <= 8'd0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            rem    <= N_in[15:8];
            dvd_lo <= N_in[7:0];
            dvs    <= D_in;
            quo    <= 8'd0;
            cnt    <= 3'd0;
            if (reject) begin
               Q_out <= 8'hFF;
               R_out <= 8'h00;
               done  <= 1'b1;
            end
         end else if (state == CALC) begin
            rem    <= rem_step;
            quo    <= quo_step;
            dvd_lo <= {dvd_lo[6:0], 1'b0};
            cnt    <= cnt + 3'd1;
            if (last) begin
               Q_out <= quo_step;
               R_out <= rem_step;
               done  <= 1'b1;
            end
         end
      end
   end

`ifdef DIV_PRECHECK_EN
   // err follows the result registers: it only changes when a new result is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                err <= 1'b0;
      else if (accept && reject) err <= 1'b1;
      else if (last)             err <= 1'b0;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_one_seq_div_sixteen_by_eight.sv
// Self-checking bench for the sequential 16/8 divider; reference results come from plain / and %.
module tb_one_seq_div_sixteen_by_eight;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] N_in;
   logic [7:0]  D_in;
   logic [7:0]  Q_out;
   logic [7:0]  R_out;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   one_seq_div_sixteen_by_eight dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .N_in  (N_in),
      .D_in  (D_in),
      .Q_out (Q_out),
      .R_out (R_out),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Launch one operation and follow it until busy drops (bounded).
   task automatic run_op(input logic [15:0] n, input logic [7:0] d, input bit rel,
                         output logic [7:0] q, output logic [7:0] r, output logic e,
                         output int lat, output int bcnt, output int dcnt);
      @(negedge clk);
      if (rel) rst_n = 1'b1;
      N_in = n; D_in = d; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; N_in = 16'($urandom); D_in = 8'($urandom);
      lat = 0; bcnt = 0; dcnt = 0; q = 8'h00; r = 8'h00; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (!busy) break;
         bcnt++;
         if (done) begin
            dcnt++;
            if (lat == 0) begin lat = i; q = Q_out; r = R_out; e = err; end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({Q_out, R_out, busy, done, err} !== 19'd0) begin
         failures++;
         $display("FAIL reset_state: got Q=%h R=%h busy=%b done=%b err=%b, want all zero",
                  Q_out, R_out, busy, done, err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] q, r; logic e; int lat, bcnt, dcnt;
      run_op(16'h03E8, 8'h19, 1'b0, q, r, e, lat, bcnt, dcnt);
      checks++;
      if ({q, r, e} !== {8'h28, 8'h00, 1'b0} || lat != 9 || dcnt != 1) begin
         failures++;
         $display("FAIL basic_03E8: got Q=%h R=%h err=%b lat=%0d pulses=%0d, want Q=28 R=00 err=0 lat=9 pulses=1",
                  q, r, e, lat, dcnt);
      end
      run_op(16'hFE01, 8'hFF, 1'b0, q, r, e, lat, bcnt, dcnt);
      checks++;
      if ({q, r, e} !== {8'hFF, 8'h00, 1'b0} || bcnt != 9) begin
         failures++;
         $display("FAIL basic_FE01: got Q=%h R=%h err=%b busy_cycles=%0d, want Q=FF R=00 err=0 busy_cycles=9",
                  q, r, e, bcnt);
      end
   endtask

   // Second start mid-CALC and a start in DONE must both be dropped; outputs hold during CALC.
   task automatic test_ignore_start();
      logic [7:0] q, r; logic e; int lat; bit hold_bad;
      logic [7:0] prev_q, prev_r;
      prev_q = 8'hFF; prev_r = 8'h00;
      @(negedge clk);
      N_in = 16'h03E8; D_in = 8'h19; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0; hold_bad = 0; q = 8'h00; r = 8'h00; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 4) begin start = 1'b1; N_in = 16'h0000; D_in = 8'h03; end
         else if (i == 5) start = 1'b0;
         if (done) begin lat = i; q = Q_out; r = R_out; e = err; break; end
         if (Q_out !== prev_q || R_out !== prev_r) hold_bad = 1;
         @(negedge clk);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({q, r, e} !== {8'h28, 8'h00, 1'b0} || lat != 9) begin
         failures++;
         $display("FAIL ignore_mid_calc: got Q=%h R=%h err=%b lat=%0d, want Q=28 R=00 err=0 lat=9",
                  q, r, e, lat);
      end
      checks++;
      if (hold_bad) begin
         failures++;
         $display("FAIL hold_mid_calc: outputs changed during CALC, want held at Q=%h R=%h", prev_q, prev_r);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL ignore_done_start: got busy=%b done=%b, want busy=0 done=0", busy, done);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [7:0] q, r; logic e; int lat, bcnt, dcnt; bit saw_done;
      @(negedge clk);
      N_in = 16'h03E8; D_in = 8'h19; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({Q_out, R_out, busy, done, err} !== 19'd0) begin
         failures++;
         $display("FAIL reset_mid_calc: got Q=%h R=%h busy=%b done=%b err=%b, want all zero",
                  Q_out, R_out, busy, done, err);
      end
      saw_done = 0;
      repeat (4) begin @(negedge clk); if (done || busy) saw_done = 1; end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL reset_no_done: got done/busy activity during reset, want none");
      end
      run_op(16'h0064, 8'h07, 1'b1, q, r, e, lat, bcnt, dcnt);
      checks++;
      if ({q, r, e} !== {8'h0E, 8'h02, 1'b0} || lat != 9) begin
         failures++;
         $display("FAIL after_reset_0064: got Q=%h R=%h err=%b lat=%0d, want Q=0E R=02 err=0 lat=9",
                  q, r, e, lat);
      end
   endtask

   task automatic test_precheck();
      logic [7:0] q, r; logic e; int lat, bcnt, dcnt;
      logic [7:0] dv;
      for (int k = 0; k < 2; k++) begin
         dv = (k == 0) ? 8'h12 : 8'h00;
         run_op(16'h1234, dv, 1'b0, q, r, e, lat, bcnt, dcnt);
`ifdef DIV_PRECHECK_EN
         checks++;
         if ({q, r, e} !== {8'hFF, 8'h00, 1'b1} || lat != 1 || bcnt != 1) begin
            failures++;
            $display("FAIL precheck_D%h: got Q=%h R=%h err=%b lat=%0d busy_cycles=%0d, want Q=FF R=00 err=1 lat=1 busy_cycles=1",
                     dv, q, r, e, lat, bcnt);
         end
`else
         checks++;
         if (e !== 1'b0 || lat != 9 || bcnt != 9) begin
            failures++;
            $display("FAIL noprecheck_D%h: got err=%b lat=%0d busy_cycles=%0d, want err=0 lat=9 busy_cycles=9",
                     dv, e, lat, bcnt);
         end
`endif
      end
      // A normal operation afterwards clears err.
      run_op(16'h0100, 8'h10, 1'b0, q, r, e, lat, bcnt, dcnt);
      checks++;
      if ({q, r, e} !== {8'h10, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL precheck_recover: got Q=%h R=%h err=%b, want Q=10 R=00 err=0", q, r, e);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic [7:0] q1, r1, q2, r2;
      t1 = 0; t2 = 0; q1 = 0; r1 = 0; q2 = 0; r2 = 0;
      @(negedge clk);
      N_in = 16'd5000; D_in = 8'd77; start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            if (t1 == 0) begin
               t1 = i; q1 = Q_out; r1 = R_out;
               N_in = 16'd1234; D_in = 8'd200;
            end else begin
               t2 = i; q2 = Q_out; r2 = R_out;
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (t2 - t1 != 10 || t1 != 9) begin
         failures++;
         $display("FAIL b2b_spacing: got first=%0d spacing=%0d, want first=9 spacing=10", t1, t2 - t1);
      end
      checks++;
      if ({q1, r1, q2, r2} !== {8'(5000 / 77), 8'(5000 % 77), 8'(1234 / 200), 8'(1234 % 200)}) begin
         failures++;
         $display("FAIL b2b_results: got %h/%h %h/%h, want %h/%h %h/%h", q1, r1, q2, r2,
                  8'(5000 / 77), 8'(5000 % 77), 8'(1234 / 200), 8'(1234 % 200));
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] q, r; logic e; int lat, bcnt, dcnt;
      int unsigned d, nhi, n;
      for (int k = 0; k < 2000; k++) begin
         d   = $urandom_range(255, 1);
         nhi = $urandom_range(d - 1, 0);
         n   = (nhi << 8) | ($urandom & 32'hFF);
         run_op(16'(n), 8'(d), 1'b0, q, r, e, lat, bcnt, dcnt);
         checks++;
         if (q !== 8'(n / d) || r !== 8'(n % d) || lat != 9) begin
            failures++;
            $display("FAIL random_%0d: N=%h D=%h got Q=%h R=%h lat=%0d, want Q=%h R=%h lat=9",
                     k, n[15:0], d[7:0], q, r, lat, 8'(n / d), 8'(n % d));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; N_in = 16'h0000; D_in = 8'h00;
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_mid_calc();
      test_precheck();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
